// File: rtl/ram_dp_be_if.sv
// Bus bundle for ram_dp_be: chip select, write port with byte enables,
// read port with registered data and valid strobe.
interface ram_dp_be_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  cs;
  logic                  ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  ready, rd_data, rd_valid
  );

  modport slave (
    input  cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output ready, rd_data, rd_valid
  );
endinterface

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-enable writes, 1/2-cycle registered reads,
// selectable read-during-write policy and a post-reset clear sequencer.
module ram_dp_be #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        rst,
  ram_dp_be_if.slave bus
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int BE_WIDTH  = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  ready;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  vld_out;
  logic [DATA_WIDTH-1:0] data_out;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr == {ADDR_WIDTH{1'b1}}) state_nxt = RUN;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      if (clr_we) clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end
  end

  // Port access is blocked until ready, so the sequencer owns the write path while clearing.
  assign wr_acc = bus.cs && bus.wr_en && ready && !rst;
  assign rd_acc = bus.cs && bus.rd_en && ready && !rst;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = bus.wr_addr;
    mem_data = bus.wr_data;
    mem_be   = bus.wr_be;
    if (clr_we && !rst) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = '0;
      mem_be   = '1;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (mem_we && mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
    end
  end

  // Write-first mode forwards the merged word; read-first sees the pre-edge contents.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (RDW_MODE != 0 && wr_acc && bus.wr_addr == bus.rd_addr)
      rd_word = merge_bytes(mem[bus.rd_addr], bus.wr_data, bus.wr_be);
  end

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      // Stage p0: array read lands directly in the output register.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_out  <= 1'b0;
          data_out <= '0;
        end else begin
          vld_out <= rd_acc;
          if (rd_acc) data_out <= rd_word;
        end
      end
    end else begin : g_lat2
      logic                  vld_p0;
      logic [DATA_WIDTH-1:0] data_p0;

      // Stage p0: array read.
      always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= rd_acc;
      end

      always_ff @(posedge clk) begin
        if (rd_acc) data_p0 <= rd_word;
      end

      // Stage p1: output register, holds its value between valid results.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_out  <= 1'b0;
          data_out <= '0;
        end else begin
          vld_out <= vld_p0;
          if (vld_p0) data_out <= data_p0;
        end
      end
    end
  endgenerate

  assign bus.ready    = ready;
  assign bus.rd_valid = vld_out;
  assign bus.rd_data  = data_out;
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: two instances (latency 1/read-first and latency 2/write-first)
// driven with identical stimulus and checked with immediate assertions.
module tb_ram_dp_be;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  int          total = 0;
  int          bad   = 0;
  int          n;

  always #5 clk = ~clk;

  ram_dp_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b1 ();
  ram_dp_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b2 ();

  assign b1.cs = cs;      assign b2.cs = cs;
  assign b1.wr_en = wr_en;     assign b2.wr_en = wr_en;
  assign b1.wr_addr = wr_addr; assign b2.wr_addr = wr_addr;
  assign b1.wr_data = wr_data; assign b2.wr_data = wr_data;
  assign b1.wr_be = wr_be;     assign b2.wr_be = wr_be;
  assign b1.rd_en = rd_en;     assign b2.rd_en = rd_en;
  assign b1.rd_addr = rd_addr; assign b2.rd_addr = rd_addr;

  ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0),
              .CLEAR_ON_RESET(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1),
              .CLEAR_ON_RESET(1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    cs = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  // One read; u1 answers after one edge, u2 after two.
  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] e1, input logic [15:0] e2);
    cs = 1'b1; rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk1({tag, "_v1"}, b1.rd_valid, 1'b1);
    chk16({tag, "_d1"}, b1.rd_data, e1);
    chk1({tag, "_v2early"}, b2.rd_valid, 1'b0);
    step();
    chk1({tag, "_v2"}, b2.rd_valid, 1'b1);
    chk16({tag, "_d2"}, b2.rd_data, e2);
    chk1({tag, "_v1once"}, b1.rd_valid, 1'b0);
  endtask

  // Counts edges until ready while hammering both ports; nothing may get through.
  task automatic wait_clear(input string tag);
    n = 0;
    cs = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd0;
    while (b2.ready !== 1'b1 && n < 40) begin
      step();
      n++;
      chk1({tag, "_v1"}, b1.rd_valid, 1'b0);
      chk1({tag, "_v2"}, b2.rd_valid, 1'b0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk16({tag, "_edges"}, 16'(n), 16'd16);
    chk1({tag, "_rdy1"}, b1.ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] e;
    rst = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (2) step();

    chk1("rst_ready", b1.ready, 1'b0);
    chk1("rst_vld1", b1.rd_valid, 1'b0);
    chk1("rst_vld2", b2.rd_valid, 1'b0);
    chk16("rst_data1", b1.rd_data, 16'h0000);
    chk16("rst_data2", b2.rd_data, 16'h0000);

    rst = 1'b0;
    wait_clear("clear");
    for (int a = 0; a < 16; a++) rd("clr_rd", 4'(a), 16'h0000, 16'h0000);

    wr(4'd3, 16'hA5A5, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd("be_merge", 4'd3, 16'hA534, 16'hA534);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd("be_none", 4'd3, 16'hA534, 16'hA534);

    wr(4'd5, 16'h1111, 2'b11);
    cs = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk1("rdw_v1", b1.rd_valid, 1'b1);
    chk16("rdw_old", b1.rd_data, 16'h1111);
    step();
    chk1("rdw_v2", b2.rd_valid, 1'b1);
    chk16("rdw_new", b2.rd_data, 16'h2222);
    rd("rdw_after", 4'd5, 16'h2222, 16'h2222);

    for (int a = 0; a < 8; a++) wr(4'(a), 16'h0100 + 16'(a), 2'b11);
    cs = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      rd_en = (k <= 8); rd_addr = 4'(k - 1);
      step();
      chk1("str_v1", b1.rd_valid, (k <= 8));
      if (k <= 8) begin
        e = 16'h0100 + 16'(k - 1);
        chk16("str_d1", b1.rd_data, e);
      end
      chk1("str_v2", b2.rd_valid, (k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) begin
        e = 16'h0100 + 16'(k - 2);
        chk16("str_d2", b2.rd_data, e);
      end
    end
    rd_en = 1'b0;

    cs = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd4;
    step();
    chk1("cs0_v1", b1.rd_valid, 1'b0);
    step();
    chk1("cs0_v2", b2.rd_valid, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0;
    rd("cs0_mem", 4'd4, 16'h0104, 16'h0104);

    cs = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
    step();
    rd_en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("mid_v2", b2.rd_valid, 1'b0);
    chk16("mid_d2", b2.rd_data, 16'h0000);
    chk16("mid_d1", b1.rd_data, 16'h0000);
    chk1("mid_ready", b2.ready, 1'b0);
    wait_clear("reclear");
    rd("reclr_rd", 4'd7, 16'h0000, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Simple dual-port synchronous RAM with independent write and read ports, per-byte write enables, a selectable 1- or 2-cycle registered read pipeline with a `rd_valid` strobe, and a selectable read-during-write policy. After reset, a built-in clear sequencer zeroes every location. `ready` stays low until the clear completes. It is the general-purpose storage block for buffers and register files that need concurrent read/write and partial-word updates.

## Interface
- `DATA_WIDTH`, 8: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 8: address width; depth `RAM_DEPTH = 1 << ADDR_WIDTH`.
- `RD_LATENCY`, 1: read latency in cycles; legal values are 1 or 2.
- `RDW_MODE`, 0: same-address read-during-write policy. 0 = old data (read-first); 1 = new data (write-first).
- `CLEAR_ON_RESET`, 1: 1 = zero all locations after reset; 0 = skip the clear, contents undefined.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `cs` input 1: chip select; gates both ports.
- `ready` output 1: high when the RAM accepts accesses.
- `wr_en` input 1: write request.
- `wr_addr` input `ADDR_WIDTH`: write address.
- `wr_data` input `DATA_WIDTH`: write data.
- `wr_be` input `DATA_WIDTH/8`: byte enables; bit i covers `wr_data[8i+7:8i]`.
- `rd_en` input 1: read request.
- `rd_addr` input `ADDR_WIDTH`: read address.
- `rd_data` output `DATA_WIDTH`: registered read data.
- `rd_valid` output 1: `rd_data` holds the result of an accepted read.

## Operation
- **States:**
  - CLEAR: sequencer writing zeros.
  - RUN: normal operation.
- **Reset:** any edge with `rst`=1 does the following.
  - Sets state to CLEAR, or to RUN if `CLEAR_ON_RESET`=0.
  - Sets clear counter to 0.
  - Drives `ready`=0, `rd_valid`=0, `rd_data`=0, and flushes all pipeline stages.
- **CLEAR:** on each edge with `rst`=0:
  - writes 0 to `mem[clr_addr]` and increments `clr_addr`;
  - when `clr_addr`=`RAM_DEPTH`-1, moves to RUN and sets `ready`=1.
- **CLEAR_ON_RESET=0:** `ready`=1 after the first edge with `rst`=0.
- **Write acceptance:** a write is accepted when `cs && wr_en && ready`.
  - Only bytes with `wr_be[i]`=1 are updated; other bytes keep their contents.
  - `wr_be`=0 is a legal no-op.
- **Read acceptance:** a read is accepted when `cs && rd_en && ready`. It produces exactly one `rd_valid` pulse `RD_LATENCY` edges later.
- **Same-edge write and read to the same address:**
  - `RDW_MODE`=0: returns the pre-write word.
  - `RDW_MODE`=1: returns the merged word (enabled bytes from `wr_data`, others from old contents).
- **Different addresses:** the two ports are fully independent.
- **Ignored requests:** requests while `ready`=0 or `cs`=0 are ignored.
  - Memory is unchanged.
  - No `rd_valid` is produced for them.
- **Idle cycles:** in cycles with no valid read emerging, `rd_valid`=0 and `rd_data` holds its last value.
- **Reset mid-operation:** in-flight reads are dropped with no `rd_valid`, and the clear restarts from address 0.

## Timing
- **Reset values:** `ready`=0, `rd_valid`=0, `rd_data`=0.
- **`ready` rise:** `ready` is high after the `RAM_DEPTH`-th edge following reset deassertion (`CLEAR_ON_RESET`=1), or after the 1st edge (`CLEAR_ON_RESET`=0).
- **RD_LATENCY=1:**
  - Read sampled on edge N.
  - `rd_data`/`rd_valid` are updated on edge N and visible during cycle N+1.
- **RD_LATENCY=2:** same as above with one extra register stage; visible in cycle N+2.
- **Throughput:** back-to-back reads produce one result per cycle.
- **Write-then-read:** a write on edge N is visible to a read sampled on edge N+1 in both modes.
- **Sequencer priority:** writes on the write port cannot collide with the clear sequencer, because the port is blocked while `ready`=0.

## Test plan
Bench configuration: `DATA_WIDTH`=16, `ADDR_WIDTH`=4.
- **Reset/clear:** pulse `rst` for 2 cycles, then read all 16 addresses.
  - `ready` rises after exactly 16 edges.
  - Every read returns 0x0000, and `rd_valid` is never high before `ready`.
- **Byte enables:**
  - Write 0xA5A5 to addr 3 with `wr_be`=11, then 0x1234 with `wr_be`=01.
  - Read addr 3 returns 0xA534.
  - Write with `wr_be`=00 leaves the location unchanged.
- **Read-during-write:** addr 5 holds 0x1111; on one edge, write 0x2222 (`wr_be`=11) and read addr 5.
  - `RDW_MODE`=0 returns 0x1111; `RDW_MODE`=1 returns 0x2222.
  - The next read returns 0x2222 in both modes.
- **Latency/streaming:** `RD_LATENCY`=2, 8 consecutive reads of addrs 0..7 preloaded with 0x0100+addr.
  - `rd_valid` asserts 2 cycles after the first request and stays high for 8 cycles.
  - Data arrives in order 0x0100..0x0107.
- **Gating:**
  - Requests with `cs`=0 produce no `rd_valid` and no memory change.
  - A write issued while `ready`=0 (during clear) to addr 2 leaves addr 2 at 0x0000.
- **Reset mid-read:** assert `rst` one edge after a read is accepted (`RD_LATENCY`=2).
  - No `rd_valid` appears for that read.
  - `rd_data`=0, and the clear reruns the full 16 cycles.
